// File: rtl/if_id_ex_frontend.sv
// Fetch / decode front end: fetch PC, instruction memory, IF/ID register, register file,
// decoder and ID/EX register. Every pipeline register advances only when CNTEN is high.
module if_id_ex_frontend #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                          CLK,
  input  logic                          RSTB,
  input  logic                          CNTEN,
  input  logic                          PCsel,
  input  logic [31:0]                   JumporBranch,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          RegWrite,
  input  logic [4:0]                    wb_rd,
  input  logic [31:0]                   regfile_indata,
  output logic [31:0]                   IFIDOUTInst,
  output logic [31:0]                   IFIDOUTPC,
  output logic [31:0]                   PC,
  output logic [31:0]                   rs1val,
  output logic [31:0]                   rs2val,
  output logic [31:0]                   LoadStoreOrjalAddress,
  output logic [31:0]                   auipcOrlui,
  output logic [4:0]                    ex_rd,
  output logic [2:0]                    ex_funct3,
  output logic                          ex_RegWrite,
  output logic                          Dmem1ALUOUT,
  output logic                          DmemREB,
  output logic                          DmemWEB,
  output logic                          ALUSourceA,
  output logic [3:0]                    ALUControl,
  output logic [2:0]                    ALUSourceB
);
  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1val;
    logic [31:0] rs2val;
    logic [31:0] lsaddr;
    logic [31:0] upper;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        dmem_alu_out;
    logic        dmem_reb;
    logic        dmem_web;
    logic        src_a;
    logic [3:0]  alu_ctrl;
    logic [2:0]  src_b;
  } idex_t;

  logic [31:0] r_pc_f;
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_rf [32];
  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc;
  idex_t       r_idex;

  logic [AW-1:0] w_imem_idx;
  logic [31:0]   w_fetch_inst;
  logic [6:0]    w_opcode;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [2:0]    w_funct3;
  logic [31:0]   w_rs1_val;
  logic [31:0]   w_rs2_val;
  idex_t         w_dec;

  assign w_imem_idx   = r_pc_f[AW+1:2];
  assign w_fetch_inst = r_imem[w_imem_idx];

  always_ff @(posedge CLK) begin
    if (imem_we) r_imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      r_pc_f      <= '0;
      r_ifid_inst <= NOP_INST;
      r_ifid_pc   <= '0;
    end else if (CNTEN) begin
      r_pc_f      <= PCsel ? JumporBranch : r_pc_f + 32'd4;
      r_ifid_inst <= PCsel ? NOP_INST : w_fetch_inst;
      r_ifid_pc   <= r_pc_f;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (RegWrite && (wb_rd != 5'd0)) begin
      r_rf[wb_rd] <= regfile_indata;
    end
  end

  assign w_opcode = r_ifid_inst[6:0];
  assign w_rs1    = r_ifid_inst[19:15];
  assign w_rs2    = r_ifid_inst[24:20];
  assign w_funct3 = r_ifid_inst[14:12];

  // A write-back landing on this edge is forwarded so decode never sees the stale value.
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                     (RegWrite && wb_rd == w_rs1) ? regfile_indata : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                     (RegWrite && wb_rd == w_rs2) ? regfile_indata : r_rf[w_rs2];

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'd0:    code = alt ? 4'd1 : 4'd0;
      3'd1:    code = 4'd2;
      3'd2:    code = 4'd3;
      3'd3:    code = 4'd4;
      3'd4:    code = 4'd5;
      3'd5:    code = alt ? 4'd7 : 4'd6;
      3'd6:    code = 4'd8;
      default: code = 4'd9;
    endcase
    return code;
  endfunction

  always_comb begin
    w_dec          = '0;
    w_dec.dmem_reb = 1'b1;
    w_dec.dmem_web = 1'b1;
    w_dec.pc       = r_ifid_pc;
    w_dec.rs1val   = w_rs1_val;
    w_dec.rs2val   = w_rs2_val;
    w_dec.rd       = r_ifid_inst[11:7];
    w_dec.funct3   = w_funct3;
    w_dec.upper    = {r_ifid_inst[31:12], 12'h000};
    if (w_opcode == OP_JAL)
      w_dec.lsaddr = {{11{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[19:12],
                      r_ifid_inst[20], r_ifid_inst[30:21], 1'b0};
    else if (w_opcode == OP_STORE)
      w_dec.lsaddr = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:25], r_ifid_inst[11:7]};
    else
      w_dec.lsaddr = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:20]};
    case (w_opcode)
      OP_OP: begin
        w_dec.alu_ctrl  = alu_map(w_funct3, r_ifid_inst[30]);
        w_dec.reg_write = 1'b1;
      end
      OP_OPIMM: begin
        // Immediate bit 30 only selects arithmetic shift; ADDI never becomes SUB.
        w_dec.alu_ctrl  = alu_map(w_funct3, (w_funct3 == 3'd5) && r_ifid_inst[30]);
        w_dec.src_b     = 3'b001;
        w_dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        w_dec.src_b        = 3'b001;
        w_dec.dmem_reb     = 1'b0;
        w_dec.dmem_alu_out = 1'b1;
        w_dec.reg_write    = 1'b1;
      end
      OP_STORE: begin
        w_dec.src_b    = 3'b001;
        w_dec.dmem_web = 1'b0;
      end
      OP_LUI: begin
        w_dec.alu_ctrl  = 4'd10;
        w_dec.src_b     = 3'b010;
        w_dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.src_a     = 1'b1;
        w_dec.src_b     = 3'b010;
        w_dec.reg_write = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        w_dec.src_a     = 1'b1;
        w_dec.src_b     = 3'b011;
        w_dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      r_idex          <= '0;
      r_idex.dmem_reb <= 1'b1;
      r_idex.dmem_web <= 1'b1;
    end else if (CNTEN) begin
      r_idex <= w_dec;
    end
  end

  assign IFIDOUTInst           = r_ifid_inst;
  assign IFIDOUTPC             = r_ifid_pc;
  assign PC                    = r_idex.pc;
  assign rs1val                = r_idex.rs1val;
  assign rs2val                = r_idex.rs2val;
  assign LoadStoreOrjalAddress = r_idex.lsaddr;
  assign auipcOrlui            = r_idex.upper;
  assign ex_rd                 = r_idex.rd;
  assign ex_funct3             = r_idex.funct3;
  assign ex_RegWrite           = r_idex.reg_write;
  assign Dmem1ALUOUT           = r_idex.dmem_alu_out;
  assign DmemREB               = r_idex.dmem_reb;
  assign DmemWEB               = r_idex.dmem_web;
  assign ALUSourceA            = r_idex.src_a;
  assign ALUControl            = r_idex.alu_ctrl;
  assign ALUSourceB            = r_idex.src_b;
endmodule

// File: tb/tb_if_id_ex_frontend.sv
// Bench for if_id_ex_frontend: a reference model predicts the full IF/ID + ID/EX state after
// every clock edge and queues it; a monitor compares the DUT against that queue each cycle.
module tb_if_id_ex_frontend;
  localparam int          IW  = 64;
  localparam int          AW  = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb = 1'b0, cnten = 1'b0, pcsel = 1'b0;
  logic [31:0]   jb = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic [31:0]   imem_wdata = '0;
  logic          regwrite = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic [31:0]   rf_in = '0;
  logic [31:0]   ifid_inst, ifid_pc, ex_pc, rs1v, rs2v, lsaddr, upper;
  logic [4:0]    ex_rd;
  logic [2:0]    ex_f3, srcb;
  logic          ex_rw, d1alu, reb, web, srca;
  logic [3:0]    aluc;

  if_id_ex_frontend #(.IMEM_WORDS(IW), .NOP_INST(NOP)) dut (
    .CLK(clk), .RSTB(rstb), .CNTEN(cnten), .PCsel(pcsel), .JumporBranch(jb),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .RegWrite(regwrite), .wb_rd(wb_rd), .regfile_indata(rf_in),
    .IFIDOUTInst(ifid_inst), .IFIDOUTPC(ifid_pc), .PC(ex_pc), .rs1val(rs1v), .rs2val(rs2v),
    .LoadStoreOrjalAddress(lsaddr), .auipcOrlui(upper), .ex_rd(ex_rd), .ex_funct3(ex_f3),
    .ex_RegWrite(ex_rw), .Dmem1ALUOUT(d1alu), .DmemREB(reb), .DmemWEB(web),
    .ALUSourceA(srca), .ALUControl(aluc), .ALUSourceB(srcb)
  );

  typedef struct packed {
    logic [31:0] ifid_inst, ifid_pc, pc, rs1val, rs2val, lsaddr, upper;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, d1, reb, web, srca;
    logic [3:0]  aluc;
    logic [2:0]  srcb;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  exp_t        m_st;
  logic [31:0] m_pc;
  logic [31:0] m_imem [IW];
  logic [31:0] m_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic logic [31:0] rf_peek(input logic [4:0] r, input logic rw,
                                          input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (rw && wr == r) return wd;
    return m_rf[r];
  endfunction

  // What the execute stage should see for one decoded instruction.
  function automatic exp_t decode(input exp_t e, input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opc;
    opc    = inst[6:0];
    e.pc   = pc;   e.rs1val = a;  e.rs2val = b;
    e.rd   = inst[11:7];  e.f3 = inst[14:12];
    e.upper = inst & 32'hFFFFF000;
    e.rw = 0; e.d1 = 0; e.reb = 1; e.web = 1; e.srca = 0; e.aluc = 0; e.srcb = 0;
    if (opc == OPC_JAL)
      e.lsaddr = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    else if (opc == OPC_STORE)
      e.lsaddr = 32'($signed({inst[31:25], inst[11:7]}));
    else
      e.lsaddr = 32'($signed(inst[31:20]));
    case (opc)
      OPC_OP:    begin e.aluc = alu_code(inst[14:12], inst[30]); e.rw = 1; end
      OPC_OPIMM: begin e.aluc = alu_code(inst[14:12], inst[14:12] == 3'd5 && inst[30]);
                       e.srcb = 1; e.rw = 1; end
      OPC_LOAD:  begin e.srcb = 1; e.reb = 0; e.d1 = 1; e.rw = 1; end
      OPC_STORE: begin e.srcb = 1; e.web = 0; end
      OPC_LUI:   begin e.aluc = 10; e.srcb = 2; e.rw = 1; end
      OPC_AUIPC: begin e.srca = 1; e.srcb = 2; e.rw = 1; end
      OPC_JAL, OPC_JALR: begin e.srca = 1; e.srcb = 3; e.rw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // driver: apply one cycle of inputs, predict the state after the next edge, queue it
  task automatic drive(input logic rst, input logic en, input logic sel = 0,
                       input logic [31:0] tgt = 0, input logic rw = 0, input logic [4:0] wr = 0,
                       input logic [31:0] wd = 0, input logic iwe = 0,
                       input logic [AW-1:0] ia = 0, input logic [31:0] iwd = 0);
    exp_t nx;
    rstb = rst; cnten = en; pcsel = sel; jb = tgt;
    regwrite = rw; wb_rd = wr; rf_in = wd;
    imem_we = iwe; imem_addr = ia; imem_wdata = iwd;
    nx = m_st;
    if (rst) begin
      nx = '0; nx.ifid_inst = NOP; nx.reb = 1; nx.web = 1;
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (en) begin
        nx = decode(nx, m_st.ifid_inst, m_st.ifid_pc,
                    rf_peek(m_st.ifid_inst[19:15], rw, wr, wd),
                    rf_peek(m_st.ifid_inst[24:20], rw, wr, wd));
        nx.ifid_pc   = m_pc;
        nx.ifid_inst = sel ? NOP : m_imem[m_pc[AW+1:2]];
        m_pc = sel ? tgt : m_pc + 32'd4;
      end
      if (rw && wr != 0) m_rf[wr] = wd;
    end
    if (iwe) m_imem[ia] = iwd;
    m_st = nx;
    exp_q.push_back(m_st);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] r;
    int k;
    ops = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR};
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = ops[k];
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      chk("ifid_inst", ifid_inst, e.ifid_inst);  chk("ifid_pc", ifid_pc, e.ifid_pc);
      chk("ex_pc", ex_pc, e.pc);                 chk("rs1val", rs1v, e.rs1val);
      chk("rs2val", rs2v, e.rs2val);             chk("lsaddr", lsaddr, e.lsaddr);
      chk("auipcOrlui", upper, e.upper);         chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      chk("ex_funct3", 32'(ex_f3), 32'(e.f3));   chk("ex_RegWrite", 32'(ex_rw), 32'(e.rw));
      chk("Dmem1ALUOUT", 32'(d1alu), 32'(e.d1)); chk("DmemREB", 32'(reb), 32'(e.reb));
      chk("DmemWEB", 32'(web), 32'(e.web));      chk("ALUSourceA", 32'(srca), 32'(e.srca));
      chk("ALUControl", 32'(aluc), 32'(e.aluc)); chk("ALUSourceB", 32'(srcb), 32'(e.srcb));
    end
  end

  logic [31:0] prog [IW];

  initial begin
    for (int i = 0; i < IW; i++) prog[i] = NOP;
    prog[0]  = 32'h00500093;  // addi x1,x0,5
    prog[1]  = 32'hFE112E23;  // sw x1,-4(x2)
    prog[2]  = 32'h0000A103;  // lw x2,0(x1)
    prog[3]  = 32'h123452B7;  // lui x5,0x12345
    prog[4]  = 32'h008000EF;  // jal x1,8
    prog[5]  = 32'h00028313;  // addi x6,x5,0
    prog[6]  = 32'h00000393;  // addi x7,x0,0
    prog[16] = 32'h405302B3;  // sub x5,x6,x5
    m_st = '0; m_pc = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;

    // reset held while the program is loaded
    for (int i = 0; i < IW; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, AW'(i), prog[i]);

    drive(0, 1);
    chk("d_ifid_inst0", ifid_inst, 32'h00500093); chk("d_ifid_pc0", ifid_pc, 32'h0);
    drive(0, 1);
    chk("d_addi_imm", lsaddr, 32'd5);       chk("d_addi_alu", 32'(aluc), 32'd0);
    chk("d_addi_srcb", 32'(srcb), 32'd1);   chk("d_addi_rw", 32'(ex_rw), 32'd1);
    chk("d_addi_rd", 32'(ex_rd), 32'd1);
    drive(0, 1);
    chk("d_sw_imm", lsaddr, 32'hFFFFFFFC);  chk("d_sw_web", 32'(web), 32'd0);
    chk("d_sw_rw", 32'(ex_rw), 32'd0);
    drive(0, 1);
    chk("d_lw_reb", 32'(reb), 32'd0);       chk("d_lw_d1", 32'(d1alu), 32'd1);
    drive(0, 1);
    chk("d_lui_up", upper, 32'h12345000);   chk("d_lui_alu", 32'(aluc), 32'd10);
    drive(0, 1);
    chk("d_jal_imm", lsaddr, 32'd8);        chk("d_jal_srca", 32'(srca), 32'd1);
    chk("d_jal_srcb", 32'(srcb), 32'd3);
    drive(0, 1, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    chk("d_bypass_rs1", rs1v, 32'hDEADBEEF);
    drive(0, 1, 0, 0, 1, 5'd0, 32'h12345678);
    chk("d_x0_rs1", rs1v, 32'h0);
    repeat (3) drive(0, 0);
    chk("d_hold_ifid_pc", ifid_pc, 32'h1C); chk("d_hold_ex_pc", ex_pc, 32'h18);
    drive(0, 1, 1, 32'h40);
    chk("d_redir_nop", ifid_inst, NOP);      chk("d_redir_pc", ifid_pc, 32'h20);
    drive(0, 1);
    chk("d_target_pc", ifid_pc, 32'h40);    chk("d_target_inst", ifid_inst, 32'h405302B3);

    // randomized program load while the pipeline keeps running
    for (int i = 0; i < IW; i++)
      drive(0, $urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 1), 5'($urandom),
            $urandom, 1, AW'(i), rand_inst());

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      logic r_sel;
      r_sel = ($urandom_range(0, 9) == 0);
      drive(n == 300, $urandom_range(0, 6) != 0, r_sel,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4 * IW - 1)) & ~32'd3 : $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 4) == 0, AW'($urandom), rand_inst());
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
